// File: rtl/frame_scan_scheduler.sv
// rtl/frame_scan_scheduler.sv - raster frame scan-out sequencer driving frame-memory reads and video timing
//
// Ports:
//   clk, rst                 pixel clock, asynchronous active-high reset
//   i_start                  request one frame (one-deep pending while busy)
//   i_continuous             chain frames back-to-back while high
//   o_rd_en, o_rd_addr       frame-memory read strobe and address
//   i_rd_data                read data, one cycle after o_rd_en
//   o_vsync, o_hsync, o_de   video timing (active high)
//   o_data                   pixel aligned to o_de, 0 otherwise
//   o_busy, o_frame_done     frame in progress, pulse on last frame cycle
module frame_scan_scheduler #(
    parameter int DATA_WIDTH = 24,
    parameter int HRES       = 320,
    parameter int VRES       = 240,
    parameter int HSW        = 8,
    parameter int HBP        = 8,
    parameter int HFP        = 8,
    parameter int VSW        = 2,
    parameter int VBP        = 2,
    parameter int VFP        = 2,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_continuous,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_vsync,
    output logic                  o_hsync,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int HTOTAL = HSW + HBP + HRES + HFP;
    localparam int VTOTAL = VSW + VBP + VRES + VFP;
    localparam int HC_W   = $clog2(HTOTAL);
    localparam int LC_W   = $clog2(VTOTAL);

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(HTOTAL - 1);
    localparam logic [HC_W-1:0] H_SW     = HC_W'(HSW);
    // Reads lead de by one cycle to absorb the memory latency.
    localparam logic [HC_W-1:0] RD_FIRST = HC_W'(HSW + HBP - 1);
    localparam logic [HC_W-1:0] RD_LAST  = HC_W'(HSW + HBP + HRES - 2);
    localparam logic [HC_W-1:0] H_ONE    = HC_W'(1);
    localparam logic [LC_W-1:0] L_ONE    = LC_W'(1);
    localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic [HC_W-1:0]       h_cnt;
    logic [LC_W-1:0]       l_cnt;
    logic [LC_W-1:0]       last_line;
    logic                  pending;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  de_q;
    logic                  busy;
    logic                  line_end;
    logic                  state_end;
    logic                  restart;
    logic                  rd_en;

    assign busy      = (state != S_IDLE);
    assign line_end  = (h_cnt == H_LAST);
    assign state_end = line_end && (l_cnt == last_line);
    // A start arriving on the very last cycle still chains without a gap.
    assign restart   = i_continuous || pending || i_start;
    assign rd_en     = (state == S_ACTIVE) && (h_cnt >= RD_FIRST) && (h_cnt <= RD_LAST);

    always_comb begin
        last_line  = '0;
        next_state = S_IDLE;
        case (state)
            S_VSYNC: begin
                last_line  = LC_W'(VSW - 1);
                next_state = S_VBACK;
            end
            S_VBACK: begin
                last_line  = LC_W'(VBP - 1);
                next_state = S_ACTIVE;
            end
            S_ACTIVE: begin
                last_line  = LC_W'(VRES - 1);
                next_state = S_VFRONT;
            end
            S_VFRONT: begin
                last_line  = LC_W'(VFP - 1);
                next_state = restart ? S_VSYNC : S_IDLE;
            end
            default: begin
                last_line  = '0;
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            h_cnt   <= '0;
            l_cnt   <= '0;
            pending <= 1'b0;
            rd_addr <= '0;
            de_q    <= 1'b0;
        end else begin
            de_q <= rd_en;
            if (rd_en) begin
                rd_addr <= rd_addr + A_ONE;
            end
            if (state == S_IDLE) begin
                if (i_start || i_continuous) begin
                    state   <= S_VSYNC;
                    h_cnt   <= '0;
                    l_cnt   <= '0;
                    rd_addr <= '0;
                    pending <= 1'b0;
                end
            end else begin
                if (i_start) begin
                    pending <= 1'b1;
                end
                if (line_end) begin
                    h_cnt <= '0;
                    if (state_end) begin
                        l_cnt <= '0;
                        state <= next_state;
                        if (state == S_VFRONT) begin
                            // Leaving the frame either consumes the request or ends idle.
                            pending <= 1'b0;
                            if (restart) begin
                                rd_addr <= '0;
                            end
                        end
                    end else begin
                        l_cnt <= l_cnt + L_ONE;
                    end
                end else begin
                    h_cnt <= h_cnt + H_ONE;
                end
            end
        end
    end

    assign o_busy       = busy;
    assign o_vsync      = (state == S_VSYNC);
    assign o_hsync      = busy && (h_cnt < H_SW);
    assign o_rd_en      = rd_en;
    assign o_rd_addr    = rd_en ? rd_addr : '0;
    assign o_de         = de_q;
    assign o_data       = de_q ? i_rd_data : '0;
    assign o_frame_done = (state == S_VFRONT) && state_end;

endmodule

// File: tb/tb_frame_scan_scheduler.sv
// tb/tb_frame_scan_scheduler.sv - directed self-checking bench for frame_scan_scheduler
module tb_frame_scan_scheduler;

    // Reduced geometry: HTOTAL = 2+2+4+1 = 9, VTOTAL = 2+1+3+1 = 7, frame = 63 cycles.
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_continuous = 1'b0;
    logic        o_rd_en;
    logic [3:0]  o_rd_addr;
    logic [23:0] i_rd_data;
    logic        o_vsync, o_hsync, o_de, o_busy, o_frame_done;
    logic [23:0] o_data;

    frame_scan_scheduler #(
        .DATA_WIDTH(24), .HRES(4), .VRES(3),
        .HSW(2), .HBP(2), .HFP(1),
        .VSW(2), .VBP(1), .VFP(1),
        .ADDR_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_continuous(i_continuous),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
        .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_data(o_data),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mem_f(input int a);
        return 24'(a * 3 + 'h102030);
    endfunction

    logic [23:0] mem_q = '0;
    always @(posedge clk) if (o_rd_en) mem_q <= mem_f(int'(o_rd_addr));
    assign i_rd_data = mem_q;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Negedge observer: timing model keyed on the position since the last vsync rise.
    logic mon_clr = 1'b0;
    int   rises[$];
    int   last_rise, pos, ln, h, e_addr, de_idx;
    int   vs_bad, hs_bad, rd_bad, done_bad, data_bad;
    int   de_cnt, done_cnt, done_pos, vs_hi, busy_cnt, first_de, first_rd, first_rd_addr;
    logic vs_prev, e_vs, e_hs, e_rd, e_done;

    always @(negedge clk) begin
        if (mon_clr) begin
            rises.delete();
            last_rise = 0; de_idx = 0; vs_prev = 1'b0;
            vs_bad = 0; hs_bad = 0; rd_bad = 0; done_bad = 0; data_bad = 0;
            de_cnt = 0; done_cnt = 0; done_pos = -1; vs_hi = 0; busy_cnt = 0;
            first_de = -1; first_rd = -1; first_rd_addr = -1;
        end else begin
            if (o_vsync && !vs_prev) begin
                last_rise = cyc;
                rises.push_back(cyc);
                de_idx = 0;
            end
            vs_prev = o_vsync;
            pos = cyc - last_rise;
            ln  = pos / 9;
            h   = pos % 9;
            if (o_busy) begin
                e_vs   = (ln < 2);
                e_hs   = (h < 2);
                e_rd   = (ln >= 3) && (ln <= 5) && (h >= 3) && (h <= 6);
                e_done = (pos == 62);
                e_addr = e_rd ? (ln - 3) * 4 + (h - 3) : 0;
                busy_cnt++;
            end else begin
                e_vs = 1'b0; e_hs = 1'b0; e_rd = 1'b0; e_done = 1'b0; e_addr = 0;
            end
            if (o_vsync !== e_vs) vs_bad++;
            if (o_hsync !== e_hs) hs_bad++;
            if (o_rd_en !== e_rd || int'(o_rd_addr) != e_addr) rd_bad++;
            if (o_frame_done !== e_done) done_bad++;
            if (o_vsync) vs_hi++;
            if (o_rd_en && first_rd < 0) begin
                first_rd = pos;
                first_rd_addr = int'(o_rd_addr);
            end
            if (o_de) begin
                if (first_de < 0) first_de = pos;
                if (o_data !== mem_f(de_idx)) data_bad++;
                de_idx++;
                de_cnt++;
            end else if (o_data !== 24'h0) begin
                data_bad++;
            end
            if (o_frame_done) begin
                done_cnt++;
                done_pos = pos;
            end
        end
    end

    int total = 0;
    int passed = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int rise_at(input int i);
        return (i < rises.size()) ? rises[i] : -1000;
    endfunction

    task automatic clr();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    // Pulses i_start for one cycle; returns the cycle in which vsync must first be seen.
    task automatic pulse_start(output int s);
        @(posedge clk); #1 i_start = 1'b1; s = cyc + 1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int lim, input string tag);
        for (int i = 0; i < lim && done_cnt < n; i++) @(posedge clk);
        #1 check(tag, int'(done_cnt >= n), 1);
    endtask

    task automatic check_clean(input string tag);
        check({tag, "_vsync"}, vs_bad, 0);
        check({tag, "_hsync"}, hs_bad, 0);
        check({tag, "_rd"}, rd_bad, 0);
        check({tag, "_done_pos"}, done_bad, 0);
        check({tag, "_data"}, data_bad, 0);
    endtask

    int s;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(o_busy), 0);
        check("rst_vsync", int'(o_vsync), 0);
        check("rst_rd_en", int'(o_rd_en), 0);
        check("rst_de", int'(o_de), 0);
        rst = 1'b0;
        clr();
        repeat (10) @(posedge clk);
        #1 check("idle_no_busy", busy_cnt, 0);

        // Single frame
        clr();
        pulse_start(s);
        wait_done(1, 200, "single_timeout");
        repeat (5) @(posedge clk);
        #1;
        check("single_vsync_rise", rise_at(0), s);
        check("single_rises", rises.size(), 1);
        check("single_first_rd_pos", first_rd, 30);
        check("single_first_rd_addr", first_rd_addr, 0);
        check("single_first_de_pos", first_de, 31);
        check("single_de_count", de_cnt, 12);
        check("single_vsync_width", vs_hi, 18);
        check("single_done_count", done_cnt, 1);
        check("single_done_at", done_pos, 62);
        check("single_busy_cycles", busy_cnt, 63);
        check("single_busy_end", int'(o_busy), 0);
        check_clean("single");

        // Asynchronous reset while o_de is high
        clr();
        pulse_start(s);
        for (int i = 0; i < 100 && !o_de; i++) begin
            @(posedge clk); #1;
        end
        check("rst_mid_de_seen", int'(o_de), 1);
        rst = 1'b1;
        #1;
        check("rst_mid_de", int'(o_de), 0);
        check("rst_mid_data", int'(o_data), 0);
        check("rst_mid_busy", int'(o_busy), 0);
        check("rst_mid_hsync", int'(o_hsync), 0);
        check("rst_mid_rd_en", int'(o_rd_en), 0);
        @(posedge clk); #1 rst = 1'b0;
        clr();
        repeat (80) @(posedge clk);
        #1;
        check("rst_mid_no_resume", busy_cnt, 0);
        check("rst_mid_no_vsync", rises.size(), 0);

        // Continuous mode, dropped during the third frame
        clr();
        @(posedge clk); #1 i_continuous = 1'b1; s = cyc + 1;
        wait_done(2, 200, "cont_timeout2");
        repeat (10) @(posedge clk);
        #1 i_continuous = 1'b0;
        wait_done(3, 100, "cont_timeout3");
        repeat (10) @(posedge clk);
        #1;
        check("cont_first_rise", rise_at(0), s);
        check("cont_rises", rises.size(), 3);
        check("cont_period1", rise_at(1) - rise_at(0), 63);
        check("cont_period2", rise_at(2) - rise_at(1), 63);
        check("cont_de_count", de_cnt, 36);
        check("cont_done_count", done_cnt, 3);
        check("cont_busy_cycles", busy_cnt, 189);
        check("cont_busy_end", int'(o_busy), 0);
        check_clean("cont");

        // Three starts during one frame collapse to one extra frame
        clr();
        pulse_start(s);
        repeat (5) @(posedge clk);
        pulse_start(s);
        repeat (15) @(posedge clk);
        pulse_start(s);
        repeat (20) @(posedge clk);
        pulse_start(s);
        wait_done(2, 200, "pend_timeout");
        repeat (20) @(posedge clk);
        #1;
        check("pend_rises", rises.size(), 2);
        check("pend_period", rise_at(1) - rise_at(0), 63);
        check("pend_de_count", de_cnt, 24);
        check("pend_done_count", done_cnt, 2);
        check("pend_busy_cycles", busy_cnt, 126);
        check_clean("pend");

        // Start arriving in the frame_done cycle chains without a gap
        clr();
        pulse_start(s);
        for (int i = 0; i < 100 && !o_frame_done; i++) begin
            @(posedge clk); #1;
        end
        check("chain_done_seen", int'(o_frame_done), 1);
        i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        wait_done(2, 200, "chain_timeout");
        repeat (10) @(posedge clk);
        #1;
        check("chain_rises", rises.size(), 2);
        check("chain_period", rise_at(1) - rise_at(0), 63);
        check("chain_busy_cycles", busy_cnt, 126);
        check_clean("chain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/frame_scan_scheduler.md
# frame_scan_scheduler

Sequences one raster frame out of frame memory and into the video sink (PPM file writer, display model). Generates vsync/hsync/de timing, issues the frame-memory read requests with the correct lead, and presents pixel data aligned to de. Frames are run one per start request or back-to-back in continuous mode. This is the only master of the frame-memory read port during scan-out.

## Interface
Parameters:
- DATA_WIDTH, 24, pixel width (R[23:16], G[15:8], B[7:0])
- HRES, 320, active pixels per line
- VRES, 240, active lines per frame
- HSW / HBP / HFP, 8 / 8 / 8, hsync width, back porch, front porch (clocks); HBP >= 1
- VSW / VBP / VFP, 2 / 2 / 2, vsync width, back porch, front porch (lines); each >= 1
- ADDR_WIDTH, 17, frame-memory address width; 2^ADDR_WIDTH >= HRES*VRES

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  request one frame (sampled every cycle)
- i_continuous  in  1  1 = restart a new frame immediately after each frame
- o_rd_en  out  1  frame-memory read strobe
- o_rd_addr  out  ADDR_WIDTH  read address, valid with o_rd_en
- i_rd_data  in  DATA_WIDTH  read data, fixed 1-cycle latency after o_rd_en
- o_vsync  out  1  active-high vertical sync
- o_hsync  out  1  active-high horizontal sync
- o_de  out  1  active pixel valid
- o_data  out  DATA_WIDTH  pixel, 0 when o_de = 0
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse at last cycle of a frame

## Operation
- HTOTAL = HSW+HBP+HRES+HFP (344), VTOTAL = VSW+VBP+VRES+VFP (246).
- FSM: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Non-IDLE states last VSW/VBP/VRES/VFP whole lines.
- h_cnt 0..HTOTAL-1 runs in every non-IDLE state, wraps to 0 and advances line count; line count restarts at each state entry.
- IDLE: all outputs 0. i_start=1 or i_continuous=1 -> VSYNC, h_cnt=0.
- VFRONT end: if i_continuous, pending start, or i_start that cycle -> VSYNC (no idle gap); else IDLE. o_frame_done pulses that cycle.
- i_start while busy sets a one-deep pending flag; cleared on entering VSYNC. Multiple starts in one frame collapse to one.
- Deassertion of i_continuous mid-frame: current frame completes.
- o_hsync = 1 for h_cnt < HSW in every non-IDLE line. o_vsync = 1 throughout VSYNC.
- In ACTIVE, o_rd_en = 1 for h_cnt in [HSW+HBP-1, HSW+HBP+HRES-2]; o_rd_addr increments after each read, reset to 0 on VSYNC entry; last address HRES*VRES-1 (76799), never wraps within a frame.
- o_de / o_data registered from the read one cycle earlier: o_data = i_rd_data when o_de.

## Timing
- Reset (async): state IDLE, counters, pending, address and every output 0 immediately; no partial-frame continuation after release.
- i_start sampled at edge N -> o_vsync, o_hsync, o_busy = 1 after edge N+1.
- First o_de: (VSW+VBP)*HTOTAL + HSW+HBP cycles after o_vsync rise (1392); o_de high HRES consecutive cycles per active line, HRES*VRES total.
- o_de rises exactly one cycle after first o_rd_en of a line, falls one cycle after last.
- Frame period VTOTAL*HTOTAL = 84624 cycles; continuous mode: next o_vsync rise 84624 cycles after previous.
- o_busy falls the cycle after o_frame_done when returning to IDLE; stays 1 when chaining.
- o_vsync high VSW*HTOTAL = 688 cycles.

## Test plan
- Reset: assert rst mid-ACTIVE with o_de=1 -> all outputs 0 same cycle; after release, no activity until i_start.
- Single frame, memory model returns data=addr: o_de count 76800, 240 lines x 320 pixels, o_data sequence 0..76799, o_vsync width 688, one o_frame_done, o_busy low at end.
- Latency: i_start at cycle 0 -> o_vsync rises cycle 1, first o_de cycle 1393, first o_rd_en cycle 1392 addr 0.
- Continuous: i_continuous=1 for 3 frames -> vsync rises 84624 apart, address restarts at 0 each frame; drop i_continuous in frame 3 -> IDLE after it.
- Pending start: i_start pulsed 3 times during frame 1 -> exactly one further frame, no idle gap, then IDLE.
- End-to-end with PPM writer sink: output file has 320x240 header and 76800 pixel lines matching memory contents.
